// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port and byte-wide RAM/IO bus around mem_arbiter.
// master = arbiter view, slave = requesters + RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              busy;

  modport master (
    input  rdy, if_req, if_addr, if_cancel, mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
           ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
  );

  modport slave (
    output rdy, if_req, if_addr, if_cancel, mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
           ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial owner of the RAM/IO bus: fetch and load/store requests become N byte beats.
// Read done at cycle N+2, write done at N+1 after grant; rdy low freezes beats, grants and done.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nx;
  logic              owner_mem;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        nbytes;
  logic [2:0]        cnt, cnt_nx;
  logic [31:0]       wdata_q;
  logic              pend, pend_nx;
  logic [1:0]        pidx, pidx_nx;
  logic [31:0]       if_data_q, mem_rdata_q;
  logic [2:0]        len_bytes;
  logic              if_ok, pick_mem, grant, cancel_if, capture;
  logic [ADDR_W-1:0] ram_a_c;
  logic [7:0]        ram_dout_c;
  logic              ram_wr_c, if_done_c, mem_done_c;

  always_comb begin
    len_bytes = 3'd4;
    if (bus.mem_len == 2'b00)      len_bytes = 3'd1;
    else if (bus.mem_len == 2'b01) len_bytes = 3'd2;
  end

  assign if_ok     = bus.if_req & ~bus.if_cancel;
  assign pick_mem  = bus.mem_req & (DATA_PRIO | ~if_ok);
  assign cancel_if = ~owner_mem & bus.if_cancel;
  // The RAM answers one cycle after the address whatever rdy does, so capture ignores rdy.
  assign capture   = (state == RD) & pend & ~cancel_if;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_nx    = 1'b0;
    pidx_nx    = pidx;
    grant      = 1'b0;
    ram_a_c    = '0;
    ram_dout_c = 8'h00;
    ram_wr_c   = 1'b0;
    if_done_c  = 1'b0;
    mem_done_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rdy && (pick_mem || if_ok)) begin
          grant    = 1'b1;
          state_nx = (pick_mem && bus.mem_wr) ? WR : RD;
          cnt_nx   = 3'd0;
        end
      end
      RD: begin
        if (cancel_if) begin
          state_nx = IDLE;
        end else begin
          if (bus.rdy && (cnt < nbytes)) begin
            ram_a_c = addr_q + ADDR_W'(cnt);
            cnt_nx  = cnt + 3'd1;
            pend_nx = 1'b1;
            pidx_nx = cnt[1:0];
          end
          if (pend && ({1'b0, pidx} == nbytes - 3'd1)) state_nx = DONE;
        end
      end
      WR: begin
        if (bus.rdy) begin
          ram_wr_c   = 1'b1;
          ram_a_c    = addr_q + ADDR_W'(cnt);
          ram_dout_c = wdata_q[{cnt[1:0], 3'b000} +: 8];
          cnt_nx     = cnt + 3'd1;
          if (cnt == nbytes - 3'd1) state_nx = DONE;
        end
      end
      DONE: begin
        if (cancel_if) begin
          state_nx = IDLE;
        end else if (bus.rdy) begin
          if_done_c  = ~owner_mem;
          mem_done_c = owner_mem;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      addr_q      <= '0;
      nbytes      <= 3'd0;
      cnt         <= 3'd0;
      wdata_q     <= 32'h0;
      pend        <= 1'b0;
      pidx        <= 2'd0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      pidx  <= pidx_nx;
      if (grant) begin
        owner_mem <= pick_mem;
        addr_q    <= pick_mem ? bus.mem_addr : bus.if_addr;
        nbytes    <= pick_mem ? len_bytes : 3'd4;
        wdata_q   <= bus.mem_wdata;
        // Clearing the result at grant gives zero-extension above the access length.
        if (pick_mem) mem_rdata_q <= 32'h0;
        else          if_data_q   <= 32'h0;
      end
      if (capture) begin
        if (owner_mem) mem_rdata_q[{pidx, 3'b000} +: 8] <= bus.ram_din;
        else           if_data_q[{pidx, 3'b000} +: 8]   <= bus.ram_din;
      end
    end
  end

  assign bus.ram_a     = ram_a_c;
  assign bus.ram_dout  = ram_dout_c;
  assign bus.ram_wr    = ram_wr_c;
  assign bus.if_done   = if_done_c;
  assign bus.mem_done  = mem_done_c;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed transactions push expected bus beats and
// done pulses with their cycle offsets; a monitor pops and compares every observed event.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_IFD = 2;
  localparam int K_MD  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk_d;
  } ev_t;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW)) bus0 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_PRIO(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.ADDR_W(AW), .DATA_PRIO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus0.ram_din = 8'h5A;

  ev_t         sb[$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          t0;
  int          rd30k;
  logic [7:0]  mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  task automatic expect_ev(input int k, input int c, input logic [31:0] a,
                           input logic [31:0] d, input bit cd);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d; e.chk_d = cd;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
    end
  endtask

  task automatic ram_model;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        if (bus.ram_wr) mem[bus.ram_a] = bus.ram_dout;
        else if (bus.ram_a == 32'h0003_0000) rd30k++;
      end
      bus.ram_din <= rd_byte(bus.ram_a);
    end
  endtask

  task automatic monitor;
    ev_t o;
    ev_t e;
    bit  has;
    forever begin
      @(negedge clk);
      if (rst) begin
        has   = 1'b1;
        o.cyc = cyc - t0;
        o.a   = 32'h0;
        o.d   = 32'h0;
        if (bus.ram_wr) begin
          o.kind = K_WR; o.a = bus.ram_a; o.d = {24'h0, bus.ram_dout};
        end else if (bus.ram_a != 32'h0) begin
          o.kind = K_RD; o.a = bus.ram_a;
        end else if (bus.if_done) begin
          o.kind = K_IFD; o.d = bus.if_data;
        end else if (bus.mem_done) begin
          o.kind = K_MD; o.d = bus.mem_rdata;
        end else begin
          has = 1'b0;
        end
        if (has) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: kind %0d cyc %0d a 0x%0h d 0x%0h, none expected",
                     o.kind, o.cyc, o.a, o.d);
          end else begin
            e = sb.pop_front();
            if (o.kind != e.kind || (e.cyc >= 0 && o.cyc != e.cyc) || o.a !== e.a ||
                (e.chk_d && o.d !== e.d)) begin
              n_fail++;
              $display("FAIL sb_event: got kind %0d cyc %0d a 0x%0h d 0x%0h, need kind %0d cyc %0d a 0x%0h d 0x%0h",
                       o.kind, o.cyc, o.a, o.d, e.kind, e.cyc, e.a, e.d);
            end
          end
        end
      end
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.if_done;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: if_done not seen within %0d cycles", name, budget);
    end
    next();
    bus.if_req = 1'b0;
  endtask

  task automatic wait_mem(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_done;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: mem_done not seen within %0d cycles", name, budget);
    end
    next();
    bus.mem_req = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check({name, " pending events"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic mem_op(input logic wr, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd);
    bus.mem_req = 1'b1; bus.mem_wr = wr; bus.mem_len = len;
    bus.mem_addr = a; bus.mem_wdata = wd;
  endtask

  task automatic stimulus;
    int base;
    int ifc;
    int mc;
    rst = 1'b0;
    bus.rdy = 1'b1; bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_cancel = 1'b0;
    bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0;
    bus0.rdy = 1'b1; bus0.if_req = 1'b0; bus0.if_addr = 32'h0; bus0.if_cancel = 1'b0;
    bus0.mem_req = 1'b0; bus0.mem_wr = 1'b0; bus0.mem_len = 2'b00; bus0.mem_addr = 32'h0;
    bus0.mem_wdata = 32'h0;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    mem[32'h2000] = 8'h78; mem[32'h2001] = 8'h56; mem[32'h2002] = 8'h34; mem[32'h2003] = 8'h12;
    mem[32'h3_0000] = 8'hA5;

    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset ram_a", bus.ram_a, 0);
    check("reset ram_wr", bus.ram_wr, 0);
    check("reset ram_dout", bus.ram_dout, 0);
    check("reset if_done", bus.if_done, 0);
    check("reset mem_done", bus.mem_done, 0);
    check("reset if_data", bus.if_data, 0);
    check("reset mem_rdata", bus.mem_rdata, 0);
    next();
    rst = 1'b1;

    // Plain 4-byte fetch
    next();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; t0 = cyc;
    for (int k = 0; k < 4; k++) expect_ev(K_RD, 1 + k, 32'h100 + k, 0, 1'b0);
    expect_ev(K_IFD, 6, 0, 32'h0000_0513, 1'b1);
    @(negedge clk);
    check("t1 busy c0", bus.busy, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("t1 busy c%0d", c), bus.busy, 1);
    end
    next();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t1 busy c7", bus.busy, 0);
    check("t1 if_data held", bus.if_data, 32'h0000_0513);
    drain("t1");

    // Simultaneous fetch and lw, load/store has priority
    next();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    mem_op(1'b0, 2'b11, 32'h2000, 32'h0); t0 = cyc;
    for (int k = 0; k < 4; k++) expect_ev(K_RD, 1 + k, 32'h2000 + k, 0, 1'b0);
    expect_ev(K_MD, 6, 0, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 4; k++) expect_ev(K_RD, 8 + k, 32'h100 + k, 0, 1'b0);
    expect_ev(K_IFD, 13, 0, 32'h0000_0513, 1'b1);
    wait_mem(12, "t2 mem_done");
    wait_if(12, "t2 if_done");
    drain("t2");

    // Fetch cancelled in cycle 3, lbu raised meanwhile
    next();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; t0 = cyc;
    expect_ev(K_RD, 1, 32'h100, 0, 1'b0);
    expect_ev(K_RD, 2, 32'h101, 0, 1'b0);
    expect_ev(K_RD, 5, 32'h2000, 0, 1'b0);
    expect_ev(K_MD, 7, 0, 32'h0000_0078, 1'b1);
    next(); next();
    mem_op(1'b0, 2'b00, 32'h2000, 32'h0);
    next();
    bus.if_cancel = 1'b1;
    @(negedge clk);
    check("t3 ram_a on cancel", bus.ram_a, 0);
    next();
    bus.if_req = 1'b0; bus.if_cancel = 1'b0;
    @(negedge clk);
    check("t3 busy c4", bus.busy, 0);
    wait_mem(10, "t3 mem_done");
    drain("t3");

    // sb to IO space: a single write beat
    next();
    mem_op(1'b1, 2'b00, 32'h3_0000, 32'h0000_0041); t0 = cyc;
    expect_ev(K_WR, 1, 32'h3_0000, 32'h41, 1'b1);
    expect_ev(K_MD, 2, 0, 0, 1'b0);
    wait_mem(6, "t4 mem_done");
    drain("t4");
    check("t4 ram 0x30000", rd_byte(32'h3_0000), 32'h41);

    // sh crossing into the next page
    next();
    mem_op(1'b1, 2'b01, 32'h1FFF, 32'h0000_BEEF); t0 = cyc;
    expect_ev(K_WR, 1, 32'h1FFF, 32'hEF, 1'b1);
    expect_ev(K_WR, 2, 32'h2000, 32'hBE, 1'b1);
    expect_ev(K_MD, 3, 0, 0, 1'b0);
    wait_mem(8, "t5 mem_done");
    drain("t5");

    // Fetch with rdy low in cycles 2-4
    next();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; t0 = cyc;
    expect_ev(K_RD, 1, 32'h100, 0, 1'b0);
    expect_ev(K_RD, 5, 32'h101, 0, 1'b0);
    expect_ev(K_RD, 6, 32'h102, 0, 1'b0);
    expect_ev(K_RD, 7, 32'h103, 0, 1'b0);
    expect_ev(K_IFD, 9, 0, 32'h0000_0513, 1'b1);
    next(); next();
    bus.rdy = 1'b0;
    @(negedge clk);
    check("t6 ram_a while paused", bus.ram_a, 0);
    check("t6 ram_wr while paused", bus.ram_wr, 0);
    next(); next(); next();
    bus.rdy = 1'b1;
    wait_if(10, "t6 if_done");
    drain("t6");

    // lbu from IO with rdy low in cycle 2: the IO byte is read exactly once
    base = rd30k;
    next();
    mem_op(1'b0, 2'b00, 32'h3_0000, 32'h0); t0 = cyc;
    expect_ev(K_RD, 1, 32'h3_0000, 0, 1'b0);
    expect_ev(K_MD, -1, 0, 32'h0000_0041, 1'b1);
    next(); next();
    bus.rdy = 1'b0;
    next();
    bus.rdy = 1'b1;
    wait_mem(10, "t7 mem_done");
    drain("t7");
    check("t7 reads of 0x30000", rd30k - base, 1);

    // Reset in cycle 2 of sw
    next();
    mem_op(1'b1, 2'b11, 32'h3000, 32'hDEAD_BEEF); t0 = cyc;
    expect_ev(K_WR, 1, 32'h3000, 32'hEF, 1'b1);
    next(); next();
    rst = 1'b0; bus.mem_req = 1'b0;
    #1;
    check("t8 ram_wr in reset", bus.ram_wr, 0);
    check("t8 ram_a in reset", bus.ram_a, 0);
    check("t8 busy in reset", bus.busy, 0);
    check("t8 mem_rdata in reset", bus.mem_rdata, 0);
    next();
    rst = 1'b1;
    drain("t8");
    check("t8 byte 0 written", rd_byte(32'h3000), 32'hEF);
    check("t8 byte 1 untouched", rd_byte(32'h3001), 32'h00);

    // Fetch-priority instance: fetch first, lw second
    next();
    bus0.if_req = 1'b1; bus0.if_addr = 32'h100;
    bus0.mem_req = 1'b1; bus0.mem_wr = 1'b0; bus0.mem_len = 2'b11; bus0.mem_addr = 32'h2000;
    t0 = cyc; ifc = -1; mc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.if_done) begin ifc = cyc - t0; bus0.if_req = 1'b0; end
      if (bus0.mem_done) begin mc = cyc - t0; bus0.mem_req = 1'b0; end
    end
    check("t9 if_done cycle", ifc, 6);
    check("t9 mem_done cycle", mc, 13);
    check("t9 if_data", bus0.if_data, 32'h5A5A_5A5A);
    check("t9 mem_rdata", bus0.mem_rdata, 32'h5A5A_5A5A);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; t0 = 0; rd30k = 0;
    fork
      ram_model();
      monitor();
      stimulus();
      begin
        #100000;
        n_chk++; n_fail++;
        $display("FAIL watchdog: stimulus still running at %0t", $time);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
